// File: rtl/user_pkg.sv
// rtl/user_pkg.sv - shared types for the ASCON user-side DMA engines and OBI manager ports
package user_pkg;

    // Default limit on granted-but-unanswered OBI writes per DMA engine.
    localparam int unsigned ASCON_DMA_MAX_TRANS = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] len;
    } ascon_dma_cmd_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } mgr_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        mgr_obi_a_chan_t a;
    } mgr_obi_req_t;

    typedef struct packed {
        logic err;
    } mgr_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        mgr_obi_r_chan_t r;
    } mgr_obi_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DRAIN
    } wdma_state_e;

endpackage

// File: rtl/ascon_wdma_align.sv
// rtl/ascon_wdma_align.sv - byte aligner and byte-enable generator for the ASCON write DMA
//
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   clear          command accepted: zero the residual word
//   advance        a write was formed this cycle: residual takes cur
//   off            destination byte offset within the first word
//   cur            current stream word (0 for the trailing flush write)
//   byte_idx       4k, byte index of the write being formed relative to base
//   len            transfer length in bytes
//   wdata, be      data and byte enables of write k
module ascon_wdma_align
    import user_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear,
    input  logic        advance,
    input  logic [1:0]  off,
    input  logic [31:0] cur,
    input  logic [31:0] byte_idx,
    input  logic [31:0] len,
    output logic [31:0] wdata,
    output logic [3:0]  be
);

    logic [31:0] prev;
    logic [63:0] window;
    logic [5:0]  shamt;
    logic [33:0] lo;
    logic [33:0] hi;
    logic [33:0] pos;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev <= '0;
        end else if (clear) begin
            prev <= '0;
        end else if (advance) begin
            prev <= cur;
        end
    end

    always_comb begin
        // Write k takes bytes [4-off .. 7-off] of {cur, prev}.
        shamt  = {3'd4 - {1'b0, off}, 3'b000};
        window = {cur, prev} >> shamt;
        wdata  = window[31:0];

        // 34-bit compare so off+len never wraps.
        lo  = {32'd0, off};
        hi  = lo + {2'b00, len};
        pos = '0;
        be  = '0;
        for (int i = 0; i < 4; i++) begin
            pos   = {2'b00, byte_idx} + 34'(i);
            be[i] = (pos >= lo) && (pos < hi);
        end
    end

endmodule

// File: rtl/ascon_stream_write_dma.sv
// rtl/ascon_stream_write_dma.sv - OBI manager write DMA: word stream to unaligned byte range
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   testmode_i           test mode (not used by this block)
//   mgr_req_o, mgr_rsp_i OBI manager request / response
//   awvalid/awready      command handshake; awaddr byte address, awlen byte length
//   wvalid/wready/wdata  little-endian 32-bit data stream
//   busy_o               command accepted and not yet done
//   done_o               one-cycle pulse once every write has been answered
//   err_o                sticky error from any errored response, cleared on next command
module ascon_stream_write_dma
    import user_pkg::*;
#(
    parameter int unsigned NumMaxTrans = ASCON_DMA_MAX_TRANS
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         testmode_i,
    output mgr_obi_req_t mgr_req_o,
    input  mgr_obi_rsp_t mgr_rsp_i,
    input  logic         awvalid,
    output logic         awready,
    input  logic [31:0]  awaddr,
    input  logic [31:0]  awlen,
    input  logic         wvalid,
    output logic         wready,
    input  logic [31:0]  wdata,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);

    localparam logic [2:0] MaxOut = 3'(NumMaxTrans);

    wdma_state_e    state;
    ascon_dma_cmd_t cmd;
    logic [31:0]    words_left;
    logic [31:0]    writes_left;
    logic [31:0]    byte_idx;
    logic           pend_v;
    logic [31:0]    pend_addr;
    logic [31:0]    pend_wdata;
    logic [3:0]     pend_be;
    logic [2:0]     outstanding;
    logic           done_q;
    logic           err_q;

    logic        req;
    logic        gnt_fire;
    logic        slot_free;
    logic        w_fire;
    logic        flush_fire;
    logic        load_pend;
    logic        rsp_fire;
    logic [2:0]  out_next;
    logic [31:0] cur;
    logic [31:0] al_wdata;
    logic [3:0]  al_be;
    logic [31:0] words_in;
    logic [32:0] span;
    logic [31:0] writes_in;
    logic        unused_testmode;

    assign unused_testmode = testmode_i;

    // ceil(len/4) stream words and ceil((off+len)/4) OBI writes.
    assign words_in  = {2'b00, awlen[31:2]} + {31'd0, |awlen[1:0]};
    assign span      = {1'b0, awlen} + {31'd0, awaddr[1:0]};
    assign writes_in = {1'b0, span[32:2]} + {31'd0, |span[1:0]};

    assign req        = pend_v && (outstanding < MaxOut);
    assign gnt_fire   = req && mgr_rsp_i.gnt;
    assign slot_free  = !pend_v || gnt_fire;
    assign wready     = (state == ST_XFER) && (words_left != '0) && slot_free;
    assign w_fire     = wvalid && wready;
    // Trailing write carrying only residual bytes when the range spills past the last word.
    assign flush_fire = (state == ST_XFER) && (words_left == '0) && (writes_left != '0) && slot_free;
    assign load_pend  = w_fire || flush_fire;
    // A response with nothing outstanding is a protocol error and is not counted.
    assign rsp_fire   = mgr_rsp_i.rvalid && (outstanding != '0);
    assign cur        = (words_left != '0) ? wdata : '0;

    always_comb begin
        out_next = outstanding;
        if (gnt_fire && !rsp_fire) begin
            out_next = outstanding + 3'd1;
        end else if (!gnt_fire && rsp_fire) begin
            out_next = outstanding - 3'd1;
        end
    end

    ascon_wdma_align u_align (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear    (awvalid && awready),
        .advance  (load_pend),
        .off      (cmd.addr[1:0]),
        .cur      (cur),
        .byte_idx (byte_idx),
        .len      (cmd.len),
        .wdata    (al_wdata),
        .be       (al_be)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            cmd         <= '0;
            words_left  <= '0;
            writes_left <= '0;
            byte_idx    <= '0;
            pend_v      <= 1'b0;
            pend_addr   <= '0;
            pend_wdata  <= '0;
            pend_be     <= '0;
            outstanding <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            outstanding <= out_next;
            if (mgr_rsp_i.rvalid && mgr_rsp_i.r.err) begin
                err_q <= 1'b1;
            end

            if (load_pend) begin
                pend_v      <= 1'b1;
                pend_addr   <= {cmd.addr[31:2], 2'b00} + byte_idx;
                pend_wdata  <= al_wdata;
                pend_be     <= al_be;
                byte_idx    <= byte_idx + 32'd4;
                writes_left <= writes_left - 32'd1;
                if (w_fire) begin
                    words_left <= words_left - 32'd1;
                end
            end else if (gnt_fire) begin
                pend_v <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (awvalid) begin
                        cmd         <= '{addr: awaddr, len: awlen};
                        words_left  <= words_in;
                        writes_left <= writes_in;
                        byte_idx    <= '0;
                        err_q       <= 1'b0;
                        state       <= (awlen == '0) ? ST_DRAIN : ST_XFER;
                    end
                end
                ST_XFER: begin
                    // writes_left is decremented at load, so zero here means the final write.
                    if (gnt_fire && (writes_left == '0)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (out_next == '0) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign awready       = (state == ST_IDLE);
    assign busy_o        = (state != ST_IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;
    assign mgr_req_o.req = req;
    assign mgr_req_o.a   = '{addr: pend_addr, we: pend_v, be: pend_be, wdata: pend_wdata, aid: 1'b0};

endmodule
